pir_ldr_pwm_ctrl: RTL and testbench
===================================

// Module: pir_ldr_pwm_ctrl
// PURPOSE
//  Multi-channel motion/ambient-light LED controller. Next generation of the
//  single-channel PIR/LDR PWM logic, generalised to CH channels.
//  Adds input synchronisers, a per-channel state machine, a post-motion hold
//  timer, and glitch-free duty ramping between brightness levels.
//  Sits beside the LCD path in top; one shared LDR, one PIR per channel.
// PARAMETERS
//  CH           2    number of independent LED channels (>=1)
//  CNT_W        8    PWM counter / duty register width
//  PERIOD       100  PWM period in hclk cycles (2..2^CNT_W-1)
//  IDLE_DUTY    20   dim level, in cycles high per period (<=PERIOD)
//  ACTIVE_DUTY  100  motion level (<=PERIOD; ==PERIOD gives constant on)
//  RAMP_STEP    10   duty change per PWM period while ramping (>=1)
//  HOLD_W       8    hold counter width
//  HOLD_PERIODS 50   PWM periods kept at ACTIVE_DUTY after PIR falls
// PORTS
//  hclk        in   1      system clock
//  rst_n       in   1      async active-low reset
//  pir_in      in   CH     raw PIR per channel, 1 = motion (asynchronous)
//  ldr_in      in   1      raw LDR, 1 = dark enough to light (asynchronous)
//  led_out     out  CH     registered PWM output per channel
//  state_out   out  2*CH   per-channel state, ch i at [2i+1:2i]
//  period_tick out  1      1-cycle pulse on last cycle of each PWM period
// BEHAVIOUR
//  Reset (async assert, sync release): PWM cnt=0, all duty=0, states=OFF,
//   hold counters=0, sync flops=0, led_out=0, state_out=0, period_tick=0.
//  Sync: 2-FF synchroniser on each pir_in bit and on ldr_in.
//   FSM sees an input change 2 cycles late; state_out updates 1 cycle later.
//  PWM: shared cnt 0..PERIOD-1, wraps to 0.
//   period_tick registered, high while cnt==PERIOD-1.
//   led_out[i] <= (cnt < duty[i]): registered, 1 cycle after cnt.
//  States (encoding): OFF=00 IDLE=01 ACTIVE=10 HOLD=11.
//  Transitions are evaluated every cycle on synced inputs.
//   ldr=0 overrides all others.
//   OFF:    ldr=1&pir=1 -> ACTIVE; ldr=1&pir=0 -> IDLE.
//   IDLE:   ldr=0 -> OFF; pir=1 -> ACTIVE.
//   ACTIVE: ldr=0 -> OFF; pir=0 -> HOLD, load hold=HOLD_PERIODS.
//           If HOLD_PERIODS==0, go -> IDLE instead.
//   HOLD:   ldr=0 -> OFF; pir=1 -> ACTIVE (hold discarded).
//           At period_tick, hold decrements; tick with hold==1 -> IDLE.
//  Targets: OFF 0, IDLE IDLE_DUTY, ACTIVE/HOLD ACTIVE_DUTY.
//  Duty update: only at period_tick, so there are no mid-period glitches.
//   Rising: duty=min(duty+RAMP_STEP, target). Falling: duty=max(duty-RAMP_STEP, target).
//   Arithmetic is done CNT_W+1 wide so results never wrap past 0 or 2^CNT_W-1.
//  OFF exception: duty is forced to 0 on the cycle after entering OFF,
//   without waiting for period_tick; led_out is 0 one cycle later.
//  Channels are fully independent except the shared cnt and ldr.
//  Simultaneous pir rise and ldr fall: ldr wins, channel goes to OFF.
//  Reset mid-period: outputs drop immediately; restart from cnt=0 after release.
// TESTING (defaults, CH=2)
//  1. Reset release, ldr=1, pir=0:
//     -> IDLE; duty 10 then 20 over the next two ticks.
//     -> Then led_out high exactly 20 of every 100 cycles.
//  2. From IDLE (duty 20), pir[0]=1:
//     -> state_out[1:0]=10 within 3 cycles; duty 30..100 over 8 ticks.
//     -> led_out[0] constant 1; led_out[1] still 20% duty.
//  3. Drop pir[0]:
//     -> HOLD; stays ACTIVE_DUTY for 50 ticks, then IDLE.
//     -> Duty ramps 100->20 over 8 ticks.
//  4. Re-raise pir[0] at hold=10:
//     -> ACTIVE. Next fall reloads hold to 50, verified by 50-tick count.
//  5. ldr=0 while ch0 ACTIVE and ch1 IDLE:
//     -> both OFF within 4 cycles; led_out=00 by cycle 5, without waiting for tick.
//  6. Assert rst_n=0 at cnt=37:
//     -> led_out, state_out, period_tick go to 0 with no clock edge.
//     -> After release, first period_tick at cycle 100.

Source files
------------

// File: rtl/pir_ldr_pwm_ctrl.sv
// Purpose : multi-channel PIR/LDR LED dimmer; shared PWM counter, per-channel OFF/IDLE/ACTIVE/HOLD FSM, ramped duty.
// Latency : input change seen by FSM 2 cycles late, state_out 1 cycle later; duty moves only at period_tick (OFF forces 0 next cycle).
// Backpressure: none; free-running outputs, no handshake.
//
// Ports:
//   hclk, rst_n  : clock, async active-low reset (sync release expected from the reset tree)
//   pir_in[CH]   : raw asynchronous PIR per channel, 1 = motion
//   ldr_in       : raw asynchronous LDR, 1 = dark enough to light
//   led_out[CH]  : registered PWM output per channel
//   state_out    : per-channel FSM state, channel i at [2i+1:2i]
//   period_tick  : one-cycle pulse on the last cycle of each PWM period
module pir_ldr_pwm_ctrl #(
    parameter int CH           = 2,
    parameter int CNT_W        = 8,
    parameter int PERIOD       = 100,
    parameter int IDLE_DUTY    = 20,
    parameter int ACTIVE_DUTY  = 100,
    parameter int RAMP_STEP    = 10,
    parameter int HOLD_W       = 8,
    parameter int HOLD_PERIODS = 50
) (
    input  logic              hclk,
    input  logic              rst_n,
    input  logic [CH-1:0]     pir_in,
    input  logic              ldr_in,
    output logic [CH-1:0]     led_out,
    output logic [2*CH-1:0]   state_out,
    output logic              period_tick
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_IDLE   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0]  PERIOD_M1 = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  PERIOD_M2 = CNT_W'(PERIOD - 2);
    localparam logic [CNT_W:0]    IDLE_TGT  = (CNT_W+1)'(IDLE_DUTY);
    localparam logic [CNT_W:0]    ACT_TGT   = (CNT_W+1)'(ACTIVE_DUTY);
    localparam logic [CNT_W:0]    STEP_W    = (CNT_W+1)'(RAMP_STEP);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_PERIODS);

    // Synchronisers
    logic [CH-1:0] pir_s1_q, pir_s2_q;
    logic          ldr_s1_q, ldr_s2_q;

    // Shared PWM timebase
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Per-channel state
    state_e            state_q [CH];
    state_e            state_d [CH];
    logic [HOLD_W-1:0] hold_q  [CH];
    logic [HOLD_W-1:0] hold_d  [CH];
    logic [CNT_W-1:0]  duty_q  [CH];
    logic [CNT_W-1:0]  duty_d  [CH];
    logic [CH-1:0]     led_q, led_d;

    // One ramp step toward tgt, clamped at tgt. Done one bit wider than the
    // duty register so neither direction can wrap.
    function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W:0]   tgt);
        logic [CNT_W:0] cur_w;
        logic [CNT_W:0] res;
        cur_w = {1'b0, cur};
        res   = tgt;
        if (tgt > cur_w) begin
            if ((tgt - cur_w) > STEP_W) res = cur_w + STEP_W;
        end else if (cur_w > tgt) begin
            if ((cur_w - tgt) > STEP_W) res = cur_w - STEP_W;
        end
        return res[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W:0] target(input state_e st);
        logic [CNT_W:0] t;
        t = '0;
        case (st)
            ST_IDLE:           t = IDLE_TGT;
            ST_ACTIVE, ST_HOLD: t = ACT_TGT;
            default:           t = '0;
        endcase
        return t;
    endfunction

    // Tick is registered but lines up with cnt==PERIOD-1 by decoding one count early.
    always_comb begin
        cnt_d  = (cnt_q == PERIOD_M1) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == PERIOD_M2);
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            if (!ldr_s2_q) begin
                state_d[i] = ST_OFF;
                hold_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        state_d[i] = pir_s2_q[i] ? ST_ACTIVE : ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (pir_s2_q[i]) state_d[i] = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (!pir_s2_q[i]) begin
                            if (HOLD_PERIODS == 0) begin
                                state_d[i] = ST_IDLE;
                            end else begin
                                state_d[i] = ST_HOLD;
                                hold_d[i]  = HOLD_LOAD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (pir_s2_q[i]) begin
                            state_d[i] = ST_ACTIVE;
                            hold_d[i]  = '0;
                        end else if (tick_q) begin
                            // <=1 rather than ==1 so a zero hold can never stick.
                            if (hold_q[i] <= HOLD_W'(1)) begin
                                state_d[i] = ST_IDLE;
                                hold_d[i]  = '0;
                            end else begin
                                hold_d[i] = hold_q[i] - HOLD_W'(1);
                            end
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end
        end
    end

    // Duty only moves at the period boundary so a period is never cut short,
    // except OFF which blanks immediately.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            duty_d[i] = duty_q[i];
            if (state_q[i] == ST_OFF) begin
                duty_d[i] = '0;
            end else if (tick_q) begin
                duty_d[i] = ramp(duty_q[i], target(state_q[i]));
            end
            led_d[i] = (cnt_q < duty_q[i]);
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            pir_s1_q <= '0;
            pir_s2_q <= '0;
            ldr_s1_q <= 1'b0;
            ldr_s2_q <= 1'b0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            led_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_OFF;
                hold_q[i]  <= '0;
                duty_q[i]  <= '0;
            end
        end else begin
            pir_s1_q <= pir_in;
            pir_s2_q <= pir_s1_q;
            ldr_s1_q <= ldr_in;
            ldr_s2_q <= ldr_s1_q;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                duty_q[i]  <= duty_d[i];
            end
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < CH; i++) begin
            state_out[2*i +: 2] = state_q[i];
        end
    end

    assign led_out     = led_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pir_ldr_pwm_ctrl.sv
// Bench for pir_ldr_pwm_ctrl with default parameters (CH=2, PERIOD=100).
// A monitor closes a measurement window one cycle after every period_tick:
// the window holds exactly the led samples driven by one period's duty, so its
// high-count equals that duty. Expected {state, count0, count1} per window are
// pushed by the stimulus thread and popped by the monitor.
module tb_pir_ldr_pwm_ctrl;

    logic       hclk;
    logic       rst_n;
    logic [1:0] pir_in;
    logic       ldr_in;
    logic [1:0] led_out;
    logic [3:0] state_out;
    logic       period_tick;

    pir_ldr_pwm_ctrl dut (
        .hclk        (hclk),
        .rst_n       (rst_n),
        .pir_in      (pir_in),
        .ldr_in      (ldr_in),
        .led_out     (led_out),
        .state_out   (state_out),
        .period_tick (period_tick)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // state_out encodings: {ch1, ch0}
    localparam logic [3:0] S_II = 4'b0101; // both IDLE
    localparam logic [3:0] S_IA = 4'b0110; // ch1 IDLE, ch0 ACTIVE
    localparam logic [3:0] S_IH = 4'b0111; // ch1 IDLE, ch0 HOLD

    typedef struct {
        logic [3:0] st;
        int         c0;
        int         c1;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   win   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (window %0d): got %0d, expected %0d", name, win, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input int c0, input int c1);
        exp_t e;
        e.st = st;
        e.c0 = c0;
        e.c1 = c1;
        sb.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin
                @(negedge hclk);
                guard++;
            end while (!period_tick && guard < 300);
            if (!period_tick) begin
                total++;
                bad++;
                $display("FAIL tick_timeout: got no tick in %0d cycles, expected one per 100", guard);
                return;
            end
        end
    endtask

    // Monitor
    int   acc0, acc1;
    logic prev_tick;
    exp_t cur;

    always @(negedge hclk) begin
        if (!rst_n) begin
            acc0      = 0;
            acc1      = 0;
            prev_tick = 1'b0;
        end else begin
            acc0 += int'(led_out[0]);
            acc1 += int'(led_out[1]);
            if (prev_tick) begin
                win++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL win_unexpected (window %0d): got a window, expected none", win);
                end else begin
                    cur = sb.pop_front();
                    chk("win_state", int'(state_out), int'(cur.st));
                    chk("win_led0_high", acc0, cur.c0);
                    chk("win_led1_high", acc1, cur.c1);
                end
                acc0 = 0;
                acc1 = 0;
            end
            prev_tick = period_tick;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        pir_in = 2'b00;
        ldr_in = 1'b1;
        repeat (3) @(negedge hclk);
        chk("rst_led", int'(led_out), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_tick", int'(period_tick), 0);

        // 1: dark, no motion -> IDLE, duty 0 -> 10 -> 20
        rst_n = 1'b1;
        push(S_II, 0, 0);
        push(S_II, 10, 10);
        push(S_II, 20, 20);
        push(S_II, 20, 20);
        wait_ticks(4);

        // 2: motion on ch0, ramp 20 -> 100
        pir_in = 2'b01;
        repeat (3) @(negedge hclk);
        chk("act_latency", int'(state_out[1:0]), 2);
        push(S_IA, 20, 20);
        for (int i = 0; i < 8; i++) push(S_IA, 30 + 10 * i, 20);
        push(S_IA, 100, 20);
        wait_ticks(10);

        // 3: motion gone -> HOLD 50 ticks -> IDLE, ramp 100 -> 20
        pir_in = 2'b00;
        repeat (3) @(negedge hclk);
        chk("hold_latency", int'(state_out[1:0]), 3);
        for (int i = 0; i < 49; i++) push(S_IH, 100, 20);
        push(S_II, 100, 20);
        push(S_II, 100, 20);
        for (int i = 0; i < 8; i++) push(S_II, 90 - 10 * i, 20);
        wait_ticks(59);

        // 4: re-raise during hold at hold=10, then a fresh 50-tick hold
        pir_in = 2'b01;
        push(S_IA, 20, 20);
        for (int i = 0; i < 8; i++) push(S_IA, 30 + 10 * i, 20);
        wait_ticks(9);
        pir_in = 2'b00;
        for (int i = 0; i < 40; i++) push(S_IH, 100, 20);
        wait_ticks(40);
        pir_in = 2'b01;
        push(S_IA, 100, 20);
        wait_ticks(1);
        pir_in = 2'b00;
        for (int i = 0; i < 49; i++) push(S_IH, 100, 20);
        push(S_II, 100, 20);
        wait_ticks(50);

        // 5: ch0 ACTIVE, ch1 IDLE, then light returns -> OFF without a tick
        pir_in = 2'b01;
        push(S_IA, 13, 13);
        push(S_IA, 10, 10);
        push(S_IA, 20, 20);
        push(S_IA, 30, 20);
        repeat (10) @(negedge hclk);
        chk("pre_ldr_state", int'(state_out), int'(S_IA));
        ldr_in = 1'b0;
        repeat (4) @(negedge hclk);
        chk("off_state", int'(state_out), 0);
        @(negedge hclk);
        chk("off_led", int'(led_out), 0);
        ldr_in = 1'b1;
        wait_ticks(4);

        // 6: reset mid-period at cnt=37 (ch0 duty 40, ch1 duty 20)
        repeat (38) @(negedge hclk);
        chk("pre_rst_led", int'(led_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", int'(led_out), 0);
        chk("async_rst_state", int'(state_out), 0);
        chk("async_rst_tick", int'(period_tick), 0);
        repeat (3) @(negedge hclk);
        rst_n = 1'b1;
        push(S_IA, 0, 0);
        push(S_IA, 10, 10);
        n = 1;
        while (!period_tick && n < 300) begin
            @(negedge hclk);
            n++;
        end
        chk("first_tick_cycle", n, 100);
        wait_ticks(1);
        repeat (2) @(negedge hclk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
